// File: rtl/opa_fwd_stage.sv
// opa_fwd_stage: operand-A select with RS1 forwarding, load-use stall
// detection and a valid/ready ID/EX register carrying operand A into EX.
//
// Optional feature macro: OPA_FWD_EN
//   defined   : forwarding from NUM_FWD later stages, load-use hazard,
//               o_fwd_hit and the saturating o_stall_cnt
//   undefined : operand is i_pc or i_rs1_data only, no hazard,
//               o_fwd_hit and o_stall_cnt tied to 0, i_fwd_* ignored
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_valid / o_ready       ID-side handshake
//   i_opa_sel, i_pc         1 selects PC as operand A
//   i_rs1_addr, i_rs1_data  RS1 index and register-file data
//   i_fwd_valid/rd/data     forwarding sources, index 0 youngest
//   i_fwd_is_load           source 0 is a load with data not yet valid
//   i_flush                 kill the ID/EX contents
//   o_valid / i_ready       EX-side handshake
//   o_operand_a, o_fwd_hit  registered operand and forwarded flag
//   o_stall_cnt             saturating count of load-use stall cycles
module opa_fwd_stage #(
  parameter int XLEN        = 32,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_opa_sel,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [4:0]              i_rs1_addr,
  input  logic [XLEN-1:0]         i_rs1_data,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [5*NUM_FWD-1:0]    i_fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] i_fwd_data,
  input  logic                    i_fwd_is_load,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_operand_a,
  output logic                    o_fwd_hit,
  output logic [STALL_CNT_W-1:0]  o_stall_cnt
);

  logic            w_hazard;
  logic            w_ready;
  logic            w_capture;
  logic            w_load;
  logic [XLEN-1:0] w_opa;

  logic            r_valid;
  logic [XLEN-1:0] r_opa;

`ifdef OPA_FWD_EN
  logic [NUM_FWD-1:0]     w_match;
  logic                   w_fwd_any;
  logic [XLEN-1:0]        w_fwd_data;
  logic                   w_hit;
  logic                   r_hit;
  logic [STALL_CNT_W-1:0] r_cnt;

  // x0 is hard-wired zero, so a write to it is never forwarded.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      w_match[k] = i_fwd_valid[k]
                && (i_fwd_rd[5*k +: 5] == i_rs1_addr)
                && (i_rs1_addr != 5'd0);
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd_any  = 1'b0;
    w_fwd_data = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        w_fwd_any  = 1'b1;
        w_fwd_data = i_fwd_data[XLEN*k +: XLEN];
      end
    end
  end

  assign w_hit = !i_opa_sel && w_fwd_any;

  assign w_opa = i_opa_sel ? i_pc
               : (w_fwd_any ? w_fwd_data : i_rs1_data);

  // Source 0 load data arrives a cycle late; hold ID until it moves.
  assign w_hazard = i_valid && !i_opa_sel
                 && w_match[0] && i_fwd_is_load;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hit <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_hazard && (r_cnt != '1)) begin
        r_cnt <= r_cnt + STALL_CNT_W'(1);
      end
      if (w_load) begin
        r_hit <= w_hit;
      end
    end
  end

  assign o_fwd_hit   = r_hit;
  assign o_stall_cnt = r_cnt;
`else
  logic w_unused;

  assign w_unused = ^{i_fwd_valid, i_fwd_rd,
                      i_fwd_data, i_fwd_is_load};

  assign w_opa       = i_opa_sel ? i_pc : i_rs1_data;
  assign w_hazard    = 1'b0;
  assign o_fwd_hit   = 1'b0;
  assign o_stall_cnt = '0;
`endif

  assign w_ready   = !i_reset && (!r_valid || i_ready) && !w_hazard;
  assign w_capture = i_valid && w_ready;
  // Flush wins over a capture and leaves the old operand in place.
  assign w_load    = w_capture && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_opa   <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load) begin
        r_opa <= w_opa;
      end
    end
  end

  assign o_ready     = w_ready;
  assign o_valid     = r_valid;
  assign o_operand_a = r_opa;

endmodule

// File: tb/tb_opa_fwd_stage.sv
// tb_opa_fwd_stage: directed and randomized checks of opa_fwd_stage
// against a cycle-level behavioural model of the operand stage.
module tb_opa_fwd_stage;

  localparam int XLEN = 32;
  localparam int NF   = 2;
  localparam int CW   = 16;
`ifdef OPA_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic             i_clk;
  logic             i_reset;
  logic             i_valid;
  logic             o_ready;
  logic             i_opa_sel;
  logic [XLEN-1:0]  i_pc;
  logic [4:0]       i_rs1_addr;
  logic [XLEN-1:0]  i_rs1_data;
  logic [NF-1:0]    i_fwd_valid;
  logic [5*NF-1:0]  i_fwd_rd;
  logic [XLEN*NF-1:0] i_fwd_data;
  logic             i_fwd_is_load;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_operand_a;
  logic             o_fwd_hit;
  logic [CW-1:0]    o_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_op    = '0;
  logic            m_hit   = 1'b0;
  logic [CW-1:0]   m_cnt   = '0;

  opa_fwd_stage #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_opa_sel(i_opa_sel), .i_pc(i_pc),
    .i_rs1_addr(i_rs1_addr), .i_rs1_data(i_rs1_data),
    .i_fwd_valid(i_fwd_valid), .i_fwd_rd(i_fwd_rd),
    .i_fwd_data(i_fwd_data), .i_fwd_is_load(i_fwd_is_load),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_operand_a(o_operand_a), .o_fwd_hit(o_fwd_hit),
    .o_stall_cnt(o_stall_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Index of the youngest source writing RS1, or -1 if none.
  function automatic int ref_src();
    if (!FWD_EN || i_opa_sel || i_rs1_addr == 5'd0) return -1;
    for (int k = 0; k < NF; k++)
      if (i_fwd_valid[k] && i_fwd_rd[5*k +: 5] == i_rs1_addr) return k;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] ref_opa();
    int s = ref_src();
    if (i_opa_sel) return i_pc;
    if (s >= 0) return i_fwd_data[XLEN*s +: XLEN];
    return i_rs1_data;
  endfunction

  function automatic logic ref_hazard();
    return i_valid && ref_src() == 0 && i_fwd_is_load;
  endfunction

  function automatic logic ref_ready();
    return !i_reset && (!m_valid || i_ready) && !ref_hazard();
  endfunction

  // Advance one clock and update the model from the pre-edge inputs.
  task automatic tick();
    logic hz, rdy, hit;
    logic [XLEN-1:0] op;
    hz  = ref_hazard();
    rdy = ref_ready();
    op  = ref_opa();
    hit = ref_src() >= 0;
    @(posedge i_clk);
    if (i_reset) begin
      m_valid = 0; m_op = '0; m_hit = 0; m_cnt = '0;
    end else begin
      if (hz && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (i_flush) m_valid = 0;
      else if (i_valid && rdy) begin
        m_valid = 1; m_op = op; m_hit = hit;
      end else if (m_valid && i_ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic idle();
    i_reset = 0; i_valid = 0; i_opa_sel = 0; i_pc = '0;
    i_rs1_addr = '0; i_rs1_data = '0; i_fwd_valid = '0;
    i_fwd_rd = '0; i_fwd_data = '0; i_fwd_is_load = 0;
    i_flush = 0; i_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    i_reset = 1;
    tick();
    i_reset = 0;
  endtask

  task automatic test_reset();
    idle();
    i_reset = 1; i_valid = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready); end
      tick();
    end
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++;
    if (o_operand_a !== '0) begin n_fail++; $display("FAIL reset_opa: got %h want 0", o_operand_a); end
    n_checks++;
    if (o_stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", o_stall_cnt); end
    n_checks++;
    if (o_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", o_fwd_hit); end
    i_reset = 0;
  endtask

  task automatic test_pc_select();
    do_reset();
    i_valid = 1; i_opa_sel = 1; i_pc = 32'h100;
    i_rs1_addr = 5'd4; i_rs1_data = 32'h9;
    i_fwd_valid = 2'b01; i_fwd_rd = {5'd0, 5'd4};
    i_fwd_data = {32'h0, 32'h1234}; i_fwd_is_load = 1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL pc_ready: got %b want 1", o_ready); end
    tick();
    n_checks++;
    if (o_operand_a !== 32'h100 || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL pc_opa: got %h/%b want 100/1", o_operand_a, o_valid);
    end
    n_checks++;
    if (o_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL pc_hit: got %b want 0", o_fwd_hit); end
  endtask

  task automatic test_priority();
    do_reset();
    i_valid = 1; i_rs1_addr = 5'd5; i_rs1_data = 32'h1;
    i_fwd_valid = 2'b11; i_fwd_rd = {5'd5, 5'd5};
    i_fwd_data = {32'hBBBB, 32'hAAAA};
    tick();
    n_checks++;
    if (o_operand_a !== (FWD_EN ? 32'hAAAA : 32'h1)) begin
      n_fail++; $display("FAIL prio_both: got %h want %h", o_operand_a, FWD_EN ? 32'hAAAA : 32'h1);
    end
    n_checks++;
    if (o_fwd_hit !== FWD_EN) begin n_fail++; $display("FAIL prio_hit: got %b want %b", o_fwd_hit, FWD_EN); end
    i_fwd_rd = {5'd5, 5'd7};
    tick();
    n_checks++;
    if (o_operand_a !== (FWD_EN ? 32'hBBBB : 32'h1)) begin
      n_fail++; $display("FAIL prio_src1: got %h want %h", o_operand_a, FWD_EN ? 32'hBBBB : 32'h1);
    end
    i_fwd_valid = 2'b00;
    tick();
    n_checks++;
    if (o_operand_a !== 32'h1 || o_fwd_hit !== 1'b0) begin
      n_fail++; $display("FAIL prio_none: got %h/%b want 1/0", o_operand_a, o_fwd_hit);
    end
  endtask

  task automatic test_x0();
    do_reset();
    i_valid = 1; i_rs1_addr = 5'd0; i_rs1_data = 32'h0;
    i_fwd_valid = 2'b11; i_fwd_rd = {5'd0, 5'd0};
    i_fwd_data = {32'hBEEF, 32'hDEAD}; i_fwd_is_load = 1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", o_ready); end
    tick();
    n_checks++;
    if (o_operand_a !== 32'h0 || o_fwd_hit !== 1'b0) begin
      n_fail++; $display("FAIL x0_opa: got %h/%b want 0/0", o_operand_a, o_fwd_hit);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    i_valid = 1; i_rs1_addr = 5'd3; i_rs1_data = 32'h77;
    i_fwd_valid = 2'b01; i_fwd_rd = {5'd0, 5'd3};
    i_fwd_data = {32'h0, 32'hEEEE}; i_fwd_is_load = 1;
    #1;
    n_checks++;
    if (o_ready !== !FWD_EN) begin n_fail++; $display("FAIL lu_ready: got %b want %b", o_ready, !FWD_EN); end
    tick();
    n_checks++;
    if (o_stall_cnt !== CW'(FWD_EN)) begin n_fail++; $display("FAIL lu_cnt: got %0d want %0d", o_stall_cnt, FWD_EN); end
    n_checks++;
    if (o_valid !== !FWD_EN) begin n_fail++; $display("FAIL lu_valid: got %b want %b", o_valid, !FWD_EN); end
    i_fwd_valid = 2'b10; i_fwd_rd = {5'd3, 5'd0};
    i_fwd_data = {32'h55, 32'h0}; i_fwd_is_load = 0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready2: got %b want 1", o_ready); end
    tick();
    n_checks++;
    if (o_operand_a !== (FWD_EN ? 32'h55 : 32'h77) || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL lu_opa: got %h want %h", o_operand_a, FWD_EN ? 32'h55 : 32'h77);
    end
    n_checks++;
    if (o_stall_cnt !== CW'(FWD_EN)) begin n_fail++; $display("FAIL lu_cnt2: got %0d want %0d", o_stall_cnt, FWD_EN); end
  endtask

  task automatic test_backpressure_flush();
    logic [XLEN-1:0] held;
    do_reset();
    i_valid = 1; i_opa_sel = 1; i_pc = 32'hCAFE0000;
    tick();
    held = o_operand_a;
    i_ready = 0; i_pc = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", o_ready); end
      tick();
      n_checks++;
      if (o_operand_a !== 32'hCAFE0000 || o_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: got %h/%b want cafe0000/1", o_operand_a, o_valid);
      end
    end
    i_flush = 1;
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", o_valid); end
    i_ready = 1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", o_ready); end
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_operand_a !== held) begin
      n_fail++; $display("FAIL flush_override: got %h/%b want %h/0", o_operand_a, o_valid, held);
    end
    i_flush = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_valid = 1; i_opa_sel = 1; i_ready = 1;
    for (int c = 0; c < 8; c++) begin
      i_pc = 32'h1000 + 32'(4 * c);
      tick();
      n_checks++;
      if (o_operand_a !== 32'h1000 + 32'(4 * c) || o_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_%0d: got %h/%b want %h/1", c, o_operand_a, o_valid, 32'h1000 + 32'(4 * c));
      end
    end
    i_valid = 0;
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    i_valid = 1; i_opa_sel = 1; i_pc = 32'h44; i_ready = 0;
    tick();
    i_opa_sel = 0; i_rs1_addr = 5'd2; i_fwd_valid = 2'b01;
    i_fwd_rd = {5'd0, 5'd2}; i_fwd_is_load = 1; i_ready = 1;
    tick();
    i_reset = 1;
    tick();
    i_reset = 0;
    n_checks++;
    if (o_valid !== 1'b0 || o_operand_a !== '0 || o_stall_cnt !== '0) begin
      n_fail++; $display("FAIL rst_stall: got %b/%h/%0d want 0/0/0", o_valid, o_operand_a, o_stall_cnt);
    end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    i_valid = 1; i_rs1_addr = 5'd9; i_fwd_valid = 2'b01;
    i_fwd_rd = {5'd0, 5'd9}; i_fwd_is_load = 1;
    repeat ((1 << CW) + 4) tick();
    n_checks++;
    if (o_stall_cnt !== (FWD_EN ? {CW{1'b1}} : {CW{1'b0}})) begin
      n_fail++; $display("FAIL sat_cnt: got %h want %h", o_stall_cnt, FWD_EN ? {CW{1'b1}} : {CW{1'b0}});
    end
    i_flush = 1;
    tick();
    i_flush = 0;
    n_checks++;
    if (o_stall_cnt !== m_cnt) begin n_fail++; $display("FAIL sat_flush: got %h want %h", o_stall_cnt, m_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      i_reset     = ($urandom % 60) == 0;
      i_valid     = ($urandom % 4) != 0;
      i_opa_sel   = ($urandom % 5) == 0;
      i_pc        = $urandom;
      i_rs1_addr  = 5'($urandom % 4);
      i_rs1_data  = $urandom;
      i_fwd_valid = NF'($urandom);
      for (int k = 0; k < NF; k++) begin
        i_fwd_rd[5*k +: 5]      = 5'($urandom % 4);
        i_fwd_data[XLEN*k +: XLEN] = $urandom;
      end
      i_fwd_is_load = ($urandom % 3) == 0;
      i_flush       = ($urandom % 10) == 0;
      i_ready       = ($urandom % 3) != 0;
      #1;
      n_checks++;
      if (o_ready !== ref_ready()) begin
        n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", c, o_ready, ref_ready());
      end
      tick();
      n_checks++;
      if (o_valid !== m_valid || o_operand_a !== m_op ||
          o_fwd_hit !== m_hit || o_stall_cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL rnd_state @%0d: got %b/%h/%b/%0d want %b/%h/%b/%0d", c,
                 o_valid, o_operand_a, o_fwd_hit, o_stall_cnt,
                 m_valid, m_op, m_hit, m_cnt);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_pc_select();
    test_priority();
    test_x0();
    test_load_use();
    test_backpressure_flush();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    test_stall_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
